// File: rtl/bcd_counter_mod6_pkg.sv
// Shared timer constants and BCD digit type.
// Used by the mod-6 tens digit and the mod-10 seconds digit.
package bcd_counter_mod6_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t MOD6_MAX  = 4'd5;
    localparam bcd_t MOD10_MAX = 4'd9;

    // Clamp an out-of-range load value to the digit maximum
    function automatic bcd_t bcd_sat(input bcd_t v, input bcd_t max);
        return (v > max) ? max : v;
    endfunction

endpackage

// File: rtl/bcd_counter_mod6.sv
// Tens-of-seconds BCD down-counter, 5..0 then wrap to 5.
// Async clear, sync load with saturation, terminal count at zero.
module bcd_counter_mod6
    import bcd_counter_mod6_pkg::*;
(
    input  logic       clk,
    input  logic       clrn,
    input  logic       loadn,
    input  logic       en,
    input  logic [3:0] data,
    output logic [3:0] out,
    output logic       tc
);

    localparam bcd_t MAX_VAL = MOD6_MAX;

    bcd_t r_count;
    bcd_t w_next;
    logic w_wrap;

    // Zero or an illegal code both restart the count at the maximum
    assign w_wrap = (r_count == 4'd0) || (r_count > MAX_VAL);

    // Next state: load beats count, count beats hold
    always_comb begin
        w_next = r_count;
        if (!loadn) begin
            w_next = bcd_sat(data, MAX_VAL);
        end else if (en) begin
            w_next = w_wrap ? MAX_VAL : r_count - 4'd1;
        end
    end

    // Count register, cleared asynchronously
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_count <= 4'd0;
        end else begin
            r_count <= w_next;
        end
    end

    assign out = r_count;
    assign tc  = (r_count == 4'd0);

endmodule

// File: tb/tb_bcd_counter_mod6.sv
// Self-checking bench for bcd_counter_mod6.
// Compares against an arithmetic model of the digit.
module tb_bcd_counter_mod6;

    logic       clk;
    logic       clrn;
    logic       loadn;
    logic       en;
    logic [3:0] data;
    logic [3:0] out;
    logic       tc;

    int n_checks;
    int n_fail;
    int m;

    bcd_counter_mod6 dut (
        .clk   (clk),
        .clrn  (clrn),
        .loadn (loadn),
        .en    (en),
        .data  (data),
        .out   (out),
        .tc    (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs, take one rising edge, advance the model, settle
    task automatic step(input logic ld_n, input logic [3:0] d,
                        input logic e);
        loadn = ld_n;
        data  = d;
        en    = e;
        @(posedge clk);
        if (!clrn)
            m = 0;
        else if (!ld_n)
            m = (int'(d) > 5) ? 5 : int'(d);
        else if (e)
            m = (m + 5) % 6;
        #1;
    endtask

    task automatic test_reset();
        clrn  = 1'b0;
        loadn = 1'b1;
        en    = 1'b0;
        data  = 4'd0;
        m     = 0;
        #1;
        n_checks++;
        if (out !== 4'd0 || tc !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_async: out=%0d tc=%0b want out=0 tc=1",
                     out, tc);
        end
        #14;
        n_checks++;
        if (out !== 4'd0 || tc !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold: out=%0d tc=%0b want out=0 tc=1",
                     out, tc);
        end
        @(posedge clk);
        #1;
        clrn = 1'b1;
    endtask

    task automatic test_load_count();
        step(1'b0, 4'd4, 1'b0);
        n_checks++;
        if (out !== 4'd4 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL load4: out=%0d tc=%0b want out=4 tc=0", out, tc);
        end
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 4'd0, 1'b1);
            n_checks++;
            if (out !== 4'(3 - k) || out !== 4'(m)) begin
                n_fail++;
                $display("FAIL count%0d: out=%0d want %0d", k, out, 3 - k);
            end
        end
    endtask

    task automatic test_hold_clear();
        step(1'b1, 4'd0, 1'b0);
        n_checks++;
        if (out !== 4'd2) begin
            n_fail++;
            $display("FAIL hold: out=%0d want 2", out);
        end
        #2;
        clrn = 1'b0;
        m    = 0;
        #1;
        n_checks++;
        if (out !== 4'd0 || tc !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_mid: out=%0d tc=%0b want out=0 tc=1",
                     out, tc);
        end
        @(posedge clk);
        #1;
        clrn = 1'b1;
        step(1'b1, 4'd0, 1'b1);
        n_checks++;
        if (out !== 4'd5) begin
            n_fail++;
            $display("FAIL resume_after_clear: out=%0d want 5", out);
        end
    endtask

    task automatic test_wrap();
        step(1'b0, 4'd5, 1'b0);
        n_checks++;
        if (out !== 4'd5) begin
            n_fail++;
            $display("FAIL wrap_load: out=%0d want 5", out);
        end
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 4'd0, 1'b1);
            n_checks++;
            if (out !== 4'((5 - k + 12) % 6) ||
                tc !== (((5 - k + 12) % 6) == 0)) begin
                n_fail++;
                $display("FAIL wrap%0d: out=%0d tc=%0b want out=%0d",
                         k, out, tc, (5 - k + 12) % 6);
            end
        end
    endtask

    task automatic test_priority();
        step(1'b0, 4'd3, 1'b1);
        n_checks++;
        if (out !== 4'd3) begin
            n_fail++;
            $display("FAIL load_over_en: out=%0d want 3", out);
        end
        for (int d = 6; d < 16; d++) begin
            step(1'b0, 4'(d), 1'b0);
            n_checks++;
            if (out !== 4'd5) begin
                n_fail++;
                $display("FAIL sat%0d: out=%0d want 5", d, out);
            end
            step(1'b0, 4'd1, 1'b0);
        end
        loadn = 1'b0;
        data  = 4'd4;
        clrn  = 1'b0;
        m     = 0;
        @(posedge clk);
        #1;
        n_checks++;
        if (out !== 4'd0 || tc !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_over_load: out=%0d tc=%0b want 0/1",
                     out, tc);
        end
        clrn = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                clrn = 1'b0;
                m    = 0;
                #1;
                n_checks++;
                if (out !== 4'd0) begin
                    n_fail++;
                    $display("FAIL rnd_clr%0d: out=%0d want 0", i, out);
                end
                clrn = 1'b1;
            end
            step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)));
            n_checks++;
            if (out !== 4'(m) || tc !== (m == 0)) begin
                n_fail++;
                $display("FAIL rnd%0d: out=%0d tc=%0b want out=%0d tc=%0b",
                         i, out, tc, m, (m == 0));
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_load_count();
        test_hold_clear();
        test_wrap();
        test_priority();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
